// File: rtl/uart_rx_deserializer.sv
// UART receiver: 2-flop synchronised RX, start-bit qualification, LSB-first shift, optional parity, stop check.
// Define UART_RX_MAJORITY_EN to sample each bit by 2-of-3 majority around the bit centre (resolution one cycle later).
module uart_rx_deserializer #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE   = 8,
   parameter int CNT_W      = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  DATA_VALID,
   output logic                  PAR_ERR,
   output logic                  STP_ERR,
   output logic                  BUSY
);

   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                  state_q, state_d;
   logic                    sync1_q, rx_s_q;
   logic [CNT_W-1:0]        edge_cnt_q, edge_cnt_d;
   logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
   logic                    par_en_q, par_en_d, par_typ_q, par_typ_d;
   logic                    par_bad_q, par_bad_d;
   logic                    dv_q, dv_d, pe_q, pe_d, se_q, se_d;
   logic                    bit_s;

`ifdef UART_RX_MAJORITY_EN
   localparam int SMP = PRESCALE / 2;
   logic [1:0] maj_q;

   // Holds the two samples preceding the decision cycle; the third is the live rx_s.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         maj_q <= 2'b00;
      else if (edge_cnt_q == CNT_W'(SMP - 2) || edge_cnt_q == CNT_W'(SMP - 1))
         maj_q <= {maj_q[0], rx_s_q};
   end

   assign bit_s = (maj_q[1] & maj_q[0]) | (maj_q[1] & rx_s_q) | (maj_q[0] & rx_s_q);
`else
   localparam int SMP = PRESCALE / 2 - 1;
   assign bit_s = rx_s_q;
`endif

   localparam logic [CNT_W-1:0] SMP_C  = CNT_W'(SMP);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(PRESCALE - 1);
   localparam logic [BIT_W-1:0] LBIT_C = BIT_W'(DATA_WIDTH - 1);

   logic at_smp, at_last;
   assign at_smp  = (edge_cnt_q == SMP_C);
   assign at_last = (edge_cnt_q == LAST_C);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync1_q    <= 1'b1;
         rx_s_q     <= 1'b1;
         state_q    <= IDLE;
         edge_cnt_q <= '0;
         bit_cnt_q  <= '0;
         data_q     <= '0;
         p_data_q   <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         par_bad_q  <= 1'b0;
         dv_q       <= 1'b0;
         pe_q       <= 1'b0;
         se_q       <= 1'b0;
      end else begin
         sync1_q    <= RX_IN;
         rx_s_q     <= sync1_q;
         state_q    <= state_d;
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         data_q     <= data_d;
         p_data_q   <= p_data_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         par_bad_q  <= par_bad_d;
         dv_q       <= dv_d;
         pe_q       <= pe_d;
         se_q       <= se_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      edge_cnt_d = at_last ? '0 : edge_cnt_q + CNT_W'(1);
      bit_cnt_d  = bit_cnt_q;
      data_d     = data_q;
      p_data_d   = p_data_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      par_bad_d  = par_bad_q;
      dv_d       = 1'b0;
      pe_d       = 1'b0;
      se_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            edge_cnt_d = '0;
            if (!rx_s_q) begin
               state_d   = START;
               bit_cnt_d = '0;
               par_en_d  = PAR_EN;
               par_typ_d = PAR_TYP;
               par_bad_d = 1'b0;
            end
         end
         START: begin
            if (at_smp && bit_s) begin
               state_d    = IDLE;
               edge_cnt_d = '0;
            end else if (at_last) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (at_smp)
               data_d = {bit_s, data_q[DATA_WIDTH-1:1]};
            if (at_last) begin
               if (bit_cnt_q == LBIT_C) begin
                  bit_cnt_d = '0;
                  state_d   = par_en_q ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         PARITY: begin
            if (at_smp)
               par_bad_d = bit_s != (par_typ_q ? ~^data_q : ^data_q);
            if (at_last)
               state_d = STOP;
         end
         STOP: begin
            // Resolve at the sample point so a following start bit is never missed.
            if (at_smp) begin
               se_d       = ~bit_s;
               pe_d       = par_bad_q;
               state_d    = IDLE;
               edge_cnt_d = '0;
               if (bit_s && !par_bad_q) begin
                  p_data_d = data_q;
                  dv_d     = 1'b1;
               end
            end
         end
         default: begin
            state_d    = IDLE;
            edge_cnt_d = '0;
         end
      endcase
   end

   assign P_DATA     = p_data_q;
   assign DATA_VALID = dv_q;
   assign PAR_ERR    = pe_q;
   assign STP_ERR    = se_q;
   assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer (PRESCALE=8, DATA_WIDTH=8); checks use immediate assertions.
module tb_uart_rx_deserializer;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [7:0] P_DATA;
   logic       DATA_VALID, PAR_ERR, STP_ERR, BUSY;

   int n_chk = 0;
   int n_pass = 0;
   int n_fail = 0;

   int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, busy_cyc = 0;
   logic [7:0] dv_hist [$];

   int dv0, pe0, se0, bc0;

`ifdef UART_RX_MAJORITY_EN
   localparam int STOP_CYC   = 5;
   localparam logic [7:0] GLITCH_EXP = 8'hA5;
`else
   localparam int STOP_CYC   = 4;
   localparam logic [7:0] GLITCH_EXP = 8'hAD;
`endif

   uart_rx_deserializer #(.DATA_WIDTH(8), .PRESCALE(8), .CNT_W(3)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_ERR    (PAR_ERR),
      .STP_ERR    (STP_ERR),
      .BUSY       (BUSY)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (DATA_VALID) begin
         dv_cnt++;
         dv_hist.push_back(P_DATA);
      end
      if (PAR_ERR)  pe_cnt++;
      if (STP_ERR)  se_cnt++;
      if (BUSY)     busy_cyc++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic v, input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         RX_IN = v;
         @(posedge CLK); #1;
      end
   endtask

   // Glitch inverts cycle 4 of data bit gbit (gbit < 0 for none).
   task automatic send_frame(input logic [7:0] d, input logic with_par, input logic par_bit,
                             input logic stop_bit, input int gbit);
      drive_bit(1'b0, 8);
      for (int b = 0; b < 8; b++) begin
         for (int c = 0; c < 8; c++)
            drive_bit(d[b] ^ ((b == gbit) && (c == 4)), 1);
      end
      if (with_par) drive_bit(par_bit, 8);
      drive_bit(stop_bit, 8);
   endtask

   task automatic snap();
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt; bc0 = busy_cyc;
   endtask

   initial begin
      #2;
      check("rst_p_data", P_DATA, 8'h00);
      check("rst_dv", DATA_VALID, 1'b0);
      check("rst_pe", PAR_ERR, 1'b0);
      check("rst_se", STP_ERR, 1'b0);
      check("rst_busy", BUSY, 1'b0);
      repeat (3) @(posedge CLK);
      #1 RST = 1'b1;
      drive_bit(1'b1, 4);

      // Plain frame, no parity
      snap();
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
      drive_bit(1'b1, 6);
      check("a5_dv_cnt", dv_cnt - dv0, 1);
      check("a5_p_data", P_DATA, 8'hA5);
      check("a5_pe", pe_cnt - pe0, 0);
      check("a5_se", se_cnt - se0, 0);
      check("a5_busy_now", BUSY, 1'b0);
      check("a5_busy_cyc", busy_cyc - bc0, 8 + 64 + STOP_CYC);

      // Even parity: good then bad
      PAR_EN = 1'b1; PAR_TYP = 1'b0;
      snap();
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1);
      drive_bit(1'b1, 6);
      check("3c_even_dv", dv_cnt - dv0, 1);
      check("3c_even_data", P_DATA, 8'h3C);
      check("3c_even_busy_cyc", busy_cyc - bc0, 8 + 64 + 8 + STOP_CYC);
      snap();
      send_frame(8'h55, 1'b1, 1'b1, 1'b1, -1);
      drive_bit(1'b1, 6);
      check("55_pe_cnt", pe_cnt - pe0, 1);
      check("55_dv_cnt", dv_cnt - dv0, 0);
      check("55_se_cnt", se_cnt - se0, 0);
      check("55_p_data_hold", P_DATA, 8'h3C);

      // Odd parity good, then stop error
      PAR_TYP = 1'b1;
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1);
      drive_bit(1'b1, 6);
      snap();
      send_frame(8'h81, 1'b1, 1'b1, 1'b0, -1);
      drive_bit(1'b1, 20);
      check("81_se_cnt", se_cnt - se0, 1);
      check("81_pe_cnt", pe_cnt - pe0, 0);
      check("81_dv_cnt", dv_cnt - dv0, 0);
      check("81_p_data_hold", P_DATA, 8'h3C);
      check("81_busy_idle", BUSY, 1'b0);

      // Start-bit glitch
      PAR_EN = 1'b0;
      snap();
      drive_bit(1'b0, 2);
      drive_bit(1'b1, 3);
      check("glitch_busy_mid", BUSY, 1'b1);
      drive_bit(1'b1, 10);
      check("glitch_busy_cyc", busy_cyc - bc0, STOP_CYC);
      check("glitch_busy_end", BUSY, 1'b0);
      check("glitch_flags", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);

      // Back-to-back frames
      snap();
      send_frame(8'h01, 1'b0, 1'b0, 1'b1, -1);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1, -1);
      drive_bit(1'b1, 6);
      check("b2b_dv_cnt", dv_cnt - dv0, 2);
      if (dv_hist.size() >= 2) begin
         check("b2b_first", dv_hist[dv_hist.size()-2], 8'h01);
         check("b2b_second", dv_hist[dv_hist.size()-1], 8'hFF);
      end else begin
         check("b2b_hist_size", dv_hist.size(), 2);
      end

      // Reset during data bit 4
      drive_bit(1'b0, 8);
      drive_bit(1'b1, 8);  // bit0 of A5
      drive_bit(1'b0, 8);
      drive_bit(1'b1, 8);
      drive_bit(1'b0, 8);
      drive_bit(1'b0, 4);  // half of bit 4
      check("pre_rst_busy", BUSY, 1'b1);
      RST = 1'b0;
      #1;
      check("mid_rst_p_data", P_DATA, 8'h00);
      check("mid_rst_busy", BUSY, 1'b0);
      check("mid_rst_flags", {DATA_VALID, PAR_ERR, STP_ERR}, 3'b000);
      RX_IN = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b1;
      drive_bit(1'b1, 4);
      snap();
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1);
      drive_bit(1'b1, 6);
      check("post_rst_dv", dv_cnt - dv0, 1);
      check("post_rst_data", P_DATA, 8'h5A);

      // Mid-bit glitch on bit 3
      snap();
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 3);
      drive_bit(1'b1, 6);
      check("midglitch_dv", dv_cnt - dv0, 1);
      check("midglitch_data", P_DATA, GLITCH_EXP);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
